// File: rtl/x9_mc_core.sv
// x9_mc_core: multi-cycle X9 core sequenced by an FSM (fetch/decode/execute/writeback).
// It has an 8-entry register file, carry/zero flags, and external synchronous-read memories.
module x9_mc_core #(
  parameter int DW = 8,
  parameter int PW = 12,
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic [PW-1:0] imem_addr,
  input  logic [8:0]    imem_rdata,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic          dmem_we,
  input  logic [DW-1:0] dmem_rdata,
  output logic [CW-1:0] retired
);
  localparam int XW = (DW > AW) ? DW : AW;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALTED} state_t;

  state_t            state;
  logic [PW-1:0]     pc;
  logic [8:0]        ir;
  logic [DW-1:0]     regs [8];
  logic              carry;
  logic              zero;

  logic [DW-1:0]     rd_val;
  logic [DW-1:0]     rb_val;
  logic [DW-1:0]     alu_res;
  logic              alu_c;
  logic [DW:0]       sum;
  logic signed [4:0] br_off;
  logic [PW-1:0]     pc_inc;
  logic [PW-1:0]     pc_br;
  logic              dec_mem;
  logic              dec_st;
  logic [XW-1:0]     dec_rb_ext;

  assign imem_addr = pc;
  assign rd_val    = regs[ir[4:2]];
  assign rb_val    = regs[{1'b1, ir[1:0]}];
  assign br_off    = ir[4:0];
  assign pc_inc    = pc + PW'(1);
  assign pc_br     = pc_inc + PW'(br_off);

  // Memory address and store data are set up from the fetched word, so they are stable throughout EXEC.
  assign dec_mem    = (imem_rdata[8:6] == 3'b100);
  assign dec_st     = dec_mem && imem_rdata[5];
  assign dec_rb_ext = XW'(regs[{1'b1, imem_rdata[1:0]}]);

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = carry;
    case (ir[7:5])
      3'b000: begin
        sum     = {1'b0, rd_val} + {1'b0, rb_val};
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      3'b001: begin
        sum     = {1'b0, rd_val} + {1'b0, rb_val} + (DW+1)'(carry);
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      3'b010: begin
        sum     = {1'b0, rd_val} + {1'b0, ~rb_val} + (DW+1)'(1);
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
      end
      3'b011: alu_res = rd_val & rb_val;
      3'b100: alu_res = rd_val | rb_val;
      3'b101: alu_res = rd_val ^ rb_val;
      3'b110: begin
        alu_res = {rd_val[DW-2:0], 1'b0};
        alu_c   = rd_val[DW-1];
      end
      default: begin
        alu_res = {1'b0, rd_val[DW-1:1]};
        alu_c   = rd_val[0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      done       <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      retired    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            pc      <= '0;
            carry   <= 1'b0;
            zero    <= 1'b0;
            retired <= '0;
            state   <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          ir <= imem_rdata;
          if (dec_mem) dmem_addr <= dec_rb_ext[AW-1:0];
          if (dec_st) dmem_wdata <= regs[imem_rdata[4:2]];
          dmem_we <= dec_st;
          state   <= EXEC;
        end
        EXEC: begin
          dmem_we <= 1'b0;
          if (!ir[8]) begin
            regs[ir[4:2]] <= alu_res;
            carry         <= alu_c;
            zero          <= (alu_res == '0);
            pc            <= pc_inc;
            retired       <= retired + CW'(1);
            state         <= FETCH;
          end else if (ir[7]) begin
            regs[ir[6:4]] <= DW'(ir[3:0]);
            pc            <= pc_inc;
            retired       <= retired + CW'(1);
            state         <= FETCH;
          end else begin
            case (ir[6:5])
              2'b00: state <= WB;
              2'b01: begin
                pc      <= pc_inc;
                retired <= retired + CW'(1);
                state   <= FETCH;
              end
              2'b10: begin
                pc      <= zero ? pc_inc : pc_br;
                retired <= retired + CW'(1);
                state   <= FETCH;
              end
              default: begin
                retired <= retired + CW'(1);
                done    <= 1'b1;
                state   <= HALTED;
              end
            endcase
          end
        end
        WB: begin
          regs[ir[4:2]] <= dmem_rdata;
          pc            <= pc_inc;
          retired       <= retired + CW'(1);
          state         <= FETCH;
        end
        HALTED: begin
          if (!req) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_x9_mc_core.sv
// tb_x9_mc_core: runs directed and random X9 programs through x9_mc_core and checks them
// against an instruction-level interpreter of the ISA.
module tb_x9_mc_core;
  localparam int DW    = 8;
  localparam int PW    = 12;
  localparam int AW    = 8;
  localparam int CW    = 16;
  localparam int PSIZE = 1 << PW;
  localparam int MSIZE = 1 << AW;
  localparam int MASK  = (1 << DW) - 1;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          done;
  logic [PW-1:0] imem_addr;
  logic [8:0]    imem_rdata;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_we;
  logic [DW-1:0] dmem_rdata;
  logic [CW-1:0] retired;

  x9_mc_core #(.DW(DW), .PW(PW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata), .retired(retired)
  );

  always #5 clk = ~clk;

  logic [8:0]       rom  [PSIZE];
  logic [DW-1:0]    dmem [MSIZE];
  logic [AW+DW-1:0] obs_q[$];
  logic [AW+DW-1:0] exp_q[$];

  always @(posedge clk) begin
    imem_rdata <= rom[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
    if (dmem_we) begin
      dmem[dmem_addr] = dmem_wdata;
      obs_q.push_back({dmem_addr, dmem_wdata});
    end
  end

  int checks = 0;
  int fails  = 0;
  int mr [8];
  int mmem [MSIZE];
  int exp_cycles, exp_ret, exp_halt_pc;
  int cyc;
  int wp;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [8:0] enc_alu(int op, int d, int b);
    return {1'b0, 3'(op), 3'(d), 2'(b)};
  endfunction
  function automatic logic [8:0] enc_ld(int d, int b);
    return {4'b1000, 3'(d), 2'(b)};
  endfunction
  function automatic logic [8:0] enc_st(int d, int b);
    return {4'b1001, 3'(d), 2'(b)};
  endfunction
  function automatic logic [8:0] enc_bnz(int s);
    return {4'b1010, 5'(s)};
  endfunction
  function automatic logic [8:0] enc_ldi(int d, int imm);
    return {2'b11, 3'(d), 4'(imm)};
  endfunction

  task automatic clearRom();
    for (int i = 0; i < PSIZE; i++) rom[i] = 9'b1_0110_0000;
    wp = 0;
  endtask

  task automatic emit(input logic [8:0] ins);
    rom[wp] = ins;
    wp = (wp + 1) % PSIZE;
  endtask

  // Stores every register to M[R4] and halts, exposing the final register file on the store port.
  task automatic emitDump();
    for (int r = 0; r < 8; r++) emit(enc_st(r, 0));
    emit(9'b1_0110_0000);
  endtask

  // Instruction-level interpreter: architectural effect and cycle cost of each instruction.
  task automatic runModel();
    int pc, ins, a, b, d, t, res, off, addr, steps;
    bit halted;
    int mc, mz;
    mc = 0; mz = 0; pc = 0; steps = 0; halted = 0;
    exp_cycles = 0; exp_ret = 0; exp_halt_pc = 0;
    exp_q.delete();
    for (int i = 0; i < MSIZE; i++) mmem[i] = int'(dmem[i]);
    while (!halted && steps < 20000) begin
      steps++;
      ins  = int'(rom[pc]);
      d    = (ins >> 2) & 7;
      b    = mr[4 + (ins & 3)];
      addr = b % MSIZE;
      exp_ret++;
      if (ins < 256) begin
        a = mr[d];
        res = 0;
        case ((ins >> 5) & 7)
          0: begin t = a + b;      res = t & MASK; mc = (t > MASK) ? 1 : 0; end
          1: begin t = a + b + mc; res = t & MASK; mc = (t > MASK) ? 1 : 0; end
          2: begin res = (a - b) & MASK; mc = (a >= b) ? 1 : 0; end
          3: res = a & b;
          4: res = a | b;
          5: res = a ^ b;
          6: begin res = (a * 2) & MASK; mc = (a >> (DW - 1)) & 1; end
          default: begin res = a / 2; mc = a % 2; end
        endcase
        mr[d] = res;
        mz = (res == 0) ? 1 : 0;
        exp_cycles += 3;
        pc = (pc + 1) % PSIZE;
      end else if (ins >= 384) begin
        mr[(ins >> 4) & 7] = ins & 15;
        exp_cycles += 3;
        pc = (pc + 1) % PSIZE;
      end else begin
        case ((ins >> 5) & 3)
          0: begin
            mr[d] = mmem[addr];
            exp_cycles += 4;
            pc = (pc + 1) % PSIZE;
          end
          1: begin
            exp_q.push_back({AW'(addr), DW'(mr[d])});
            mmem[addr] = mr[d];
            exp_cycles += 3;
            pc = (pc + 1) % PSIZE;
          end
          2: begin
            off = ins & 31;
            if (off >= 16) off -= 32;
            pc = (mz != 0) ? pc + 1 : pc + 1 + off;
            pc = ((pc % PSIZE) + PSIZE) % PSIZE;
            exp_cycles += 3;
          end
          default: begin
            exp_cycles += 3;
            exp_halt_pc = pc;
            halted = 1;
          end
        endcase
      end
    end
  endtask

  task automatic applyStimulus(input string name);
    runModel();
    obs_q.delete();
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({name, "_ret_clear"}, 64'(retired), 64'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({name, "_cycles"}, 64'(cyc), 64'(exp_cycles));
    checkOutput({name, "_retired"}, 64'(retired), 64'(exp_ret & 16'hFFFF));
    checkOutput({name, "_halt_pc"}, 64'(imem_addr), 64'(exp_halt_pc));
    checkOutput({name, "_st_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      checkOutput($sformatf("%s_st%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
    repeat (3) @(posedge clk);
    #1;
    checkOutput({name, "_hold_done"}, 64'(done), 64'd1);
    checkOutput({name, "_hold_pc"}, 64'(imem_addr), 64'(exp_halt_pc));
    req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({name, "_done_fall"}, 64'(done), 64'd0);
    if (cyc >= LIMIT) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int r = 0; r < 8; r++) mr[r] = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 1'b0;
    for (int i = 0; i < MSIZE; i++) dmem[i] = DW'($urandom);
    for (int r = 0; r < 8; r++) mr[r] = 0;
    clearRom();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pc", 64'(imem_addr), 64'd0);
    checkOutput("rst_we", 64'(dmem_we), 64'd0);
    checkOutput("rst_daddr", 64'(dmem_addr), 64'd0);
    checkOutput("rst_wdata", 64'(dmem_wdata), 64'd0);
    checkOutput("rst_retired", 64'(retired), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset landing in the writeback cycle of a load.
    clearRom();
    emit(enc_ldi(5, 7));
    emit(enc_ld(1, 1));
    emit(9'b1_0110_0000);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midld_daddr", 64'(dmem_addr), 64'd7);
    reset = 1'b1;
    #1;
    checkOutput("midld_done", 64'(done), 64'd0);
    checkOutput("midld_we", 64'(dmem_we), 64'd0);
    checkOutput("midld_daddr_rst", 64'(dmem_addr), 64'd0);
    checkOutput("midld_retired", 64'(retired), 64'd0);
    checkOutput("midld_pc", 64'(imem_addr), 64'd0);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 8; r++) mr[r] = 0;
    clearRom();
    emitDump();
    applyStimulus("after_reset");

    clearRom();
    emit(enc_ldi(0, 15));
    emit(enc_ldi(4, 1));
    emit(enc_alu(0, 0, 0));
    emit(9'b1_0110_0000);
    applyStimulus("add");
    checkOutput("add_12clk", 64'(cyc), 64'd12);
    checkOutput("add_ret4", 64'(retired), 64'd4);
    clearRom();
    emit(enc_st(0, 0));
    emit(9'b1_0110_0000);
    applyStimulus("add_dump");
    checkOutput("add_r0", 64'(obs_q.size() > 0 ? obs_q[0] : '0), 64'({8'h01, 8'h10}));

    clearRom();
    emit(enc_ldi(4, 1));
    emit(enc_ldi(0, 0));
    emit(enc_alu(2, 0, 0));
    emit(enc_alu(0, 0, 0));
    emit(enc_ldi(5, 0));
    emit(enc_alu(1, 1, 1));
    emitDump();
    applyStimulus("adc");

    clearRom();
    emit(enc_ldi(5, 3));
    emit(enc_ldi(1, 9));
    emit(enc_st(1, 1));
    emit(enc_ldi(1, 0));
    emit(enc_ld(1, 1));
    emit(enc_st(1, 0));
    emit(9'b1_0110_0000);
    applyStimulus("ldst");
    checkOutput("ldst_first", 64'(obs_q.size() > 0 ? obs_q[0] : '0), 64'({8'h03, 8'h09}));

    clearRom();
    emit(enc_ldi(0, 3));
    emit(enc_ldi(4, 1));
    emit(enc_alu(2, 0, 0));
    emit(enc_bnz(30));
    emitDump();
    applyStimulus("countdown");

    // Backward branch from pc 0 wraps to the top of the address space, then falls off the end back to 0.
    clearRom();
    emit(enc_bnz(16));
    emitDump();
    wp = PSIZE - 15;
    emit(enc_ldi(0, 0));
    emit(enc_alu(3, 0, 0));
    while (wp != 0) emit(enc_ldi(1, 5));
    applyStimulus("pcwrap");

    for (int p = 0; p < 8; p++) begin
      clearRom();
      for (int k = 0; k < 24; k++) begin
        case ($urandom_range(0, 9))
          4, 5:    emit(enc_ldi($urandom_range(0, 7), $urandom_range(0, 15)));
          6:       emit(enc_ld($urandom_range(0, 7), $urandom_range(0, 3)));
          7:       emit(enc_st($urandom_range(0, 7), $urandom_range(0, 3)));
          8:       emit(enc_bnz($urandom_range(0, 3)));
          default: emit(enc_alu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3)));
        endcase
      end
      emitDump();
      applyStimulus($sformatf("rand%0d", p));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
